// File: rtl/per_sft_rst_seq_if.sv
// rtl/per_sft_rst_seq_if.sv - RST-bit input, test override and sequencer status outputs
interface per_sft_rst_seq_if;
  logic testmode;
  logic rcc_per_rst;
  logic sft_rst_n;
  logic rst_ker_clk_req;
  logic rst_busy;
  logic rst_done;

  modport master (
    output testmode,
    output rcc_per_rst,
    input  sft_rst_n,
    input  rst_ker_clk_req,
    input  rst_busy,
    input  rst_done
  );

  modport slave (
    input  testmode,
    input  rcc_per_rst,
    output sft_rst_n,
    output rst_ker_clk_req,
    output rst_busy,
    output rst_done
  );
endinterface

// File: rtl/per_sft_rst_seq.sv
// rtl/per_sft_rst_seq.sv - software peripheral reset sequencer with minimum width and guarded release
module per_sft_rst_seq #(
  parameter int CNT_W           = 8,
  parameter int MIN_RST_CYCLES  = 4,
  parameter int POST_RST_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              sys_rst,
  per_sft_rst_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    POST = 2'd2
  } state_t;

  // Counters are loaded with N-1 so that state entry plus N-1 decrements gives N cycles.
  localparam logic [CNT_W-1:0] MIN_LOAD  = CNT_W'(MIN_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_RST_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sft_rst_n_q, sft_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, counter and registered-output logic of the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    sft_rst_n_d = sft_rst_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rcc_per_rst) begin
          state_d     = HOLD;
          sft_rst_n_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = MIN_LOAD;
        end
      end
      HOLD: begin
        // Release only once the minimum width has elapsed and software has cleared the bit.
        if ((cnt_q == '0) && !bus.rcc_per_rst) begin
          state_d     = POST;
          sft_rst_n_d = 1'b1;
          cnt_d       = POST_LOAD;
        end
      end
      POST: begin
        if (bus.rcc_per_rst) begin
          // Re-assertion during the guard window restarts a full reset, no completion pulse.
          state_d     = HOLD;
          sft_rst_n_d = 1'b0;
          cnt_d       = MIN_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        sft_rst_n_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; sys_rst overrides everything, including an in-flight sequence.
  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sft_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sft_rst_n_q <= sft_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Test mode masks the reset without disturbing the sequence; the kernel clock is
  // requested for exactly as long as the sequence is busy.
  assign bus.sft_rst_n       = bus.testmode | sft_rst_n_q;
  assign bus.rst_ker_clk_req = busy_q;
  assign bus.rst_busy        = busy_q;
  assign bus.rst_done        = done_q;

endmodule

// File: tb/tb_per_sft_rst_seq.sv
// tb/tb_per_sft_rst_seq.sv - randomized and directed checks of per_sft_rst_seq against a behavioural model
module tb_per_sft_rst_seq;

  logic clk = 1'b0;
  logic sys_rst;
  logic testmode;
  logic rcc;
  logic started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  per_sft_rst_seq_if bus_a ();
  per_sft_rst_seq_if bus_b ();

  assign bus_a.testmode    = testmode;
  assign bus_a.rcc_per_rst = rcc;
  assign bus_b.testmode    = testmode;
  assign bus_b.rcc_per_rst = rcc;

  per_sft_rst_seq #(.CNT_W(8), .MIN_RST_CYCLES(4), .POST_RST_CYCLES(2)) dut_a (
    .i_clk   (clk),
    .sys_rst (sys_rst),
    .bus     (bus_a.slave)
  );

  per_sft_rst_seq #(.CNT_W(8), .MIN_RST_CYCLES(1), .POST_RST_CYCLES(1)) dut_b (
    .i_clk   (clk),
    .sys_rst (sys_rst),
    .bus     (bus_b.slave)
  );

  // Behavioural model: a sequence is "low" for at least MIN cycles and until the bit is
  // seen clear, then busy for POST more cycles; age counters count cycles spent so far.
  int m_low  [2];
  int m_busy [2];
  int m_done [2];
  int m_age  [2];
  int m_post [2];
  int low_cnt [2];
  int busy_cnt[2];
  int done_cnt[2];

  function automatic int min_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int post_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_low[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_age[i] = 0; m_post[i] = 0;
      low_cnt[i] = 0; busy_cnt[i] = 0; done_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sys_rst) begin
        m_low[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_age[i] = 0; m_post[i] = 0;
      end else begin
        m_done[i] = 0;
        if (m_busy[i] == 0) begin
          if (rcc) begin
            m_busy[i] = 1; m_low[i] = 1; m_age[i] = 1;
          end
        end else if (m_low[i] != 0) begin
          if (m_age[i] >= min_of(i) && !rcc) begin
            m_low[i] = 0; m_post[i] = 1;
          end else begin
            m_age[i] = m_age[i] + 1;
          end
        end else begin
          if (rcc) begin
            m_low[i] = 1; m_age[i] = 1;
          end else if (m_post[i] >= post_of(i)) begin
            m_busy[i] = 0; m_done[i] = 1;
          end else begin
            m_post[i] = m_post[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from the clock edge.
  always @(negedge clk) begin
    if (started) begin
      chk("a_sft_rst_n", bus_a.sft_rst_n,       testmode | (m_low[0] == 0));
      chk("a_ker_req",   bus_a.rst_ker_clk_req, m_busy[0] != 0);
      chk("a_busy",      bus_a.rst_busy,        m_busy[0] != 0);
      chk("a_done",      bus_a.rst_done,        m_done[0] != 0);
      chk("b_sft_rst_n", bus_b.sft_rst_n,       testmode | (m_low[1] == 0));
      chk("b_ker_req",   bus_b.rst_ker_clk_req, m_busy[1] != 0);
      chk("b_busy",      bus_b.rst_busy,        m_busy[1] != 0);
      chk("b_done",      bus_b.rst_done,        m_done[1] != 0);
      for (int i = 0; i < 2; i++) begin
        if (m_low[i] != 0)  low_cnt[i]++;
        if (m_busy[i] != 0) busy_cnt[i]++;
        if (m_done[i] != 0) done_cnt[i]++;
      end
    end
  end

  int s_low[2], s_busy[2], s_done[2];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      s_low[i] = low_cnt[i]; s_busy[i] = busy_cnt[i]; s_done[i] = done_cnt[i];
    end
  endtask

  task automatic pin(input string nm, input int i, input int el, input int eb, input int ed);
    chki({nm, "_low"},  low_cnt[i]  - s_low[i],  el);
    chki({nm, "_busy"}, busy_cnt[i] - s_busy[i], eb);
    chki({nm, "_done"}, done_cnt[i] - s_done[i], ed);
  endtask

  initial begin
    sys_rst  = 1'b1;
    testmode = 1'b0;
    rcc      = 1'b0;
    step(2);
    started = 1'b1;
    chk("rst_sft_rst_n", bus_a.sft_rst_n, 1'b1);
    chk("rst_busy",      bus_a.rst_busy, 1'b0);
    chk("rst_ker_req",   bus_a.rst_ker_clk_req, 1'b0);
    chk("rst_done",      bus_a.rst_done, 1'b0);
    sys_rst = 1'b0;
    step(2);

    // One-cycle pulse in IDLE.
    snap();
    rcc = 1'b1; step(1); rcc = 1'b0; step(12);
    pin("pulse_a", 0, 4, 6, 1);
    pin("pulse_b", 1, 1, 2, 1);

    // Bit held for ten cycles.
    snap();
    rcc = 1'b1; step(10); rcc = 1'b0; step(14);
    pin("held_a", 0, 10, 12, 1);
    pin("held_b", 1, 10, 11, 1);

    // Re-assertion in the first POST cycle of instance a.
    snap();
    rcc = 1'b1; step(1); rcc = 1'b0; step(4); rcc = 1'b1; step(1); rcc = 1'b0; step(16);
    pin("reassert_a", 0, 8, 11, 1);
    pin("reassert_b", 1, 2, 4, 2);

    // sys_rst in the second HOLD cycle with the bit still set.
    rcc = 1'b1; step(2);
    sys_rst = 1'b1; step(1);
    chk("sysrst_sft_rst_n", bus_a.sft_rst_n, 1'b1);
    chk("sysrst_busy",      bus_a.rst_busy, 1'b0);
    chk("sysrst_done",      bus_a.rst_done, 1'b0);
    sys_rst = 1'b0; step(1);
    chk("sysrst_restart",   bus_a.sft_rst_n, 1'b0);
    rcc = 1'b0; step(12);

    // testmode masks the reset while the sequence keeps running.
    rcc = 1'b1; step(2);
    testmode = 1'b1; #1;
    chk("tm_sft_rst_n", bus_a.sft_rst_n, 1'b1);
    chk("tm_busy",      bus_a.rst_busy, 1'b1);
    step(1);
    testmode = 1'b0; #1;
    chk("tm_release", bus_a.sft_rst_n, 1'b0);
    rcc = 1'b0; step(12);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 15) rcc = ~rcc;
      if ($urandom_range(0, 99) < 3)  testmode = ~testmode;
      sys_rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    sys_rst = 1'b0; rcc = 1'b0; testmode = 1'b0;
    step(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
